// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter sharing one subordinate port between NumMgr managers, with an
// in-order response-routing FIFO. Optional grant counters: define OBI_ARB_GNT_CNT_EN.

package obi_rr_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [0:0]  a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module obi_rr_arbiter #(
    parameter int unsigned NumMgr         = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter type         obi_req_t      = obi_rr_arbiter_pkg::obi_req_t,
    parameter type         obi_rsp_t      = obi_rr_arbiter_pkg::obi_rsp_t,
    parameter int unsigned CntWidth       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  obi_req_t            sbr_req_i [NumMgr],
    output obi_rsp_t            sbr_rsp_o [NumMgr],
    output obi_req_t            mgr_req_o,
    input  obi_rsp_t            mgr_rsp_i,
    output logic                proto_err_o,
    output logic [CntWidth-1:0] gnt_cnt_o [NumMgr]
);

    localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned OccW = $clog2(MaxOutstanding + 1);

    localparam logic [IdxW-1:0] LastMgr  = IdxW'(NumMgr - 1);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(MaxOutstanding - 1);
    localparam logic [OccW-1:0] FullOcc  = OccW'(MaxOutstanding);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] sel_q, sel_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [IdxW-1:0] fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic            proto_err_q, proto_err_d;

    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] head;
    int unsigned     scan_idx;
    logic            found;
    logic            fifo_full, fifo_empty;
    logic            handshake, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastSlot) ? '0 : p + 1'b1;
    endfunction

    // Full is taken from registered occupancy so a same-cycle pop never frees a slot early.
    assign fifo_full  = (occ_q == FullOcc);
    assign fifo_empty = (occ_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    always_comb begin
        sel      = rr_q;
        found    = 1'b0;
        scan_idx = 0;
        cand     = '0;
        if (lock_q) begin
            sel = sel_q;
        end else begin
            for (int unsigned k = 0; k < NumMgr; k++) begin
                scan_idx = 32'(rr_q) + k;
                if (scan_idx >= NumMgr) begin
                    scan_idx = scan_idx - NumMgr;
                end
                cand = IdxW'(scan_idx);
                if (!found && sbr_req_i[cand].req) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mgr_req_o     = sbr_req_i[sel];
        mgr_req_o.req = sbr_req_i[sel].req & ~fifo_full & ~rst_i;
    end

    assign handshake = mgr_req_o.req & mgr_rsp_i.gnt;
    assign pop       = mgr_rsp_i.rvalid & ~fifo_empty & ~rst_i;

    // Response payload is broadcast; only the FIFO head sees rvalid.
    always_comb begin
        for (int i = 0; i < NumMgr; i++) begin
            sbr_rsp_o[i]        = mgr_rsp_i;
            sbr_rsp_o[i].gnt    = handshake & (sel == IdxW'(i));
            sbr_rsp_o[i].rvalid = pop & (head == IdxW'(i));
        end
    end

    always_comb begin
        rr_d        = rr_q;
        sel_d       = sel_q;
        lock_d      = lock_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        proto_err_d = proto_err_q | (mgr_rsp_i.rvalid & fifo_empty);

        if (handshake) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            rr_d             = (sel == LastMgr) ? '0 : sel + 1'b1;
            lock_d           = 1'b0;
        end else if (mgr_req_o.req) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (handshake && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!handshake && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            sel_q       <= '0;
            lock_q      <= 1'b0;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            sel_q       <= sel_d;
            lock_q      <= lock_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

`ifdef OBI_ARB_GNT_CNT_EN
    logic [CntWidth-1:0] gnt_cnt_q [NumMgr];
    logic [CntWidth-1:0] gnt_cnt_d [NumMgr];

    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        if (handshake && (gnt_cnt_q[sel] != '1)) begin
            gnt_cnt_d[sel] = gnt_cnt_q[sel] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_cnt_q <= '{default: '0};
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt_o = gnt_cnt_q;
`else
    always_comb begin
        for (int i = 0; i < NumMgr; i++) begin
            gnt_cnt_o[i] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed and random stimulus for obi_rr_arbiter against a transaction-level reference model.

module tb_obi_rr_arbiter;

    localparam int N    = 2;
    localparam int MAXO = 2;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic                          clk = 1'b0;
    logic                          rst;
    obi_rr_arbiter_pkg::obi_req_t  sbr_req [N];
    obi_rr_arbiter_pkg::obi_rsp_t  sbr_rsp [N];
    obi_rr_arbiter_pkg::obi_req_t  mgr_req;
    obi_rr_arbiter_pkg::obi_rsp_t  mgr_rsp;
    logic                          proto_err;
    logic [CW-1:0]                 gnt_cnt [N];

    obi_rr_arbiter #(
        .NumMgr         (N),
        .MaxOutstanding (MAXO),
        .CntWidth       (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sbr_req_i   (sbr_req),
        .sbr_rsp_o   (sbr_rsp),
        .mgr_req_o   (mgr_req),
        .mgr_rsp_i   (mgr_rsp),
        .proto_err_o (proto_err),
        .gnt_cnt_o   (gnt_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus for the next cycle
    bit          t_rst;
    bit          t_req [N];
    logic [31:0] t_addr [N];
    bit          t_gnt;
    bit          t_rv;
    logic [31:0] t_rdata;

    // Reference model: outstanding owners in issue order, round-robin start, held request
    int m_rr;
    bit m_lock;
    int m_lock_idx;
    int m_q[$];
    bit m_perr;
    int m_cnt [N];
    int last_gnt_idx;
    bit pend [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int  cand;
        int  occ;
        int  rv_idx;
        int  exp_cnt;
        bit  exp_req;
        bit  hs;
        @(negedge clk);
        rst = t_rst;
        for (int i = 0; i < N; i++) begin
            sbr_req[i]         = '0;
            sbr_req[i].req     = t_req[i];
            sbr_req[i].a.addr  = t_addr[i];
            sbr_req[i].a.wdata = ~t_addr[i];
            sbr_req[i].a.be    = 4'hF;
            sbr_req[i].a.we    = t_addr[i][0];
        end
        mgr_rsp          = '0;
        mgr_rsp.gnt      = t_gnt;
        mgr_rsp.rvalid   = t_rv;
        mgr_rsp.r.rdata  = t_rdata;
        mgr_rsp.r.err    = t_rdata[0];
        #1;
        occ  = m_q.size();
        cand = -1;
        if (!t_rst) begin
            if (m_lock) begin
                cand = m_lock_idx;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_rr + k) % N;
                    if (cand < 0 && t_req[i]) cand = i;
                end
            end
        end
        exp_req      = (cand >= 0) && t_req[cand] && (occ < MAXO);
        hs           = exp_req && t_gnt;
        last_gnt_idx = hs ? cand : -1;
        rv_idx       = (!t_rst && t_rv && occ > 0) ? m_q[0] : -1;

        check("req", 32'(mgr_req.req), 32'(exp_req));
        if (!t_rst) check("addr", mgr_req.a.addr, t_addr[(cand >= 0) ? cand : m_rr]);
        for (int i = 0; i < N; i++) begin
            check($sformatf("gnt%0d", i), 32'(sbr_rsp[i].gnt), 32'(last_gnt_idx == i));
            check($sformatf("rvalid%0d", i), 32'(sbr_rsp[i].rvalid), 32'(rv_idx == i));
            check($sformatf("rdata%0d", i), sbr_rsp[i].r.rdata, t_rdata);
`ifdef OBI_ARB_GNT_CNT_EN
            exp_cnt = m_cnt[i];
`else
            exp_cnt = 0;
`endif
            check($sformatf("cnt%0d", i), 32'(gnt_cnt[i]), 32'(exp_cnt));
        end
        check("proto_err", 32'(proto_err), 32'(m_perr));

        if (t_rst) begin
            m_rr   = 0;
            m_lock = 0;
            m_q.delete();
            m_perr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (t_rv) begin
                if (occ > 0) void'(m_q.pop_front());
                else m_perr = 1;
            end
            if (hs) begin
                m_q.push_back(cand);
                m_rr   = (cand + 1) % N;
                m_lock = 0;
                if (m_cnt[cand] < CMAX) m_cnt[cand]++;
            end else if (exp_req) begin
                m_lock     = 1;
                m_lock_idx = cand;
            end
        end
    endtask

    task automatic step(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                        input bit g, input bit rv, input logic [31:0] rd);
        t_rst     = 0;
        t_req[0]  = r0;
        t_req[1]  = r1;
        t_addr[0] = a0;
        t_addr[1] = a1;
        t_gnt     = g;
        t_rv      = rv;
        t_rdata   = rd;
        cycle();
    endtask

    task automatic reset_cycle();
        t_rst = 1;
        t_req[0] = 1;
        t_req[1] = 1;
        t_gnt = 1;
        t_rv = 1;
        t_rdata = 32'h5A5A;
        cycle();
        t_rst = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * MAXO && m_q.size() > 0; k++) begin
            step(0, 0, 32'h0, 32'h4, 0, 1, 32'h7700 + k);
        end
    endtask

    initial begin
        rst = 1'b1;
        mgr_rsp = '0;
        for (int i = 0; i < N; i++) begin
            sbr_req[i] = '0;
            m_cnt[i] = 0;
            pend[i] = 0;
        end
        m_rr = 0; m_lock = 0; m_lock_idx = 0; m_perr = 0; last_gnt_idx = -1;

        // Reset: requests and responses driven but everything suppressed
        reset_cycle();
        reset_cycle();

        // T1: both requesting, gnt every cycle, grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 32'h1000 + k, 32'h2000 + k, 1, m_q.size() > 0, 32'h100 + k);
            check("t1_alt", 32'(sbr_rsp[k % 2].gnt), 32'd1);
        end
        drain();

        // T2: mgr0 held without gnt, mgr1 joins; address held, then 0 then 1 granted
        step(1, 0, 32'h200, 32'h300, 0, 0, 32'h0);
        check("t2_addr0", mgr_req.a.addr, 32'h200);
        step(1, 1, 32'h200, 32'h300, 0, 0, 32'h0);
        check("t2_addr1", mgr_req.a.addr, 32'h200);
        step(1, 1, 32'h200, 32'h300, 0, 0, 32'h0);
        check("t2_addr2", mgr_req.a.addr, 32'h200);
        step(1, 1, 32'h200, 32'h300, 1, 0, 32'h0);
        check("t2_addr3", mgr_req.a.addr, 32'h200);
        check("t2_gnt0", 32'(sbr_rsp[0].gnt), 32'd1);
        step(0, 1, 32'h204, 32'h300, 1, 0, 32'h0);
        check("t2_gnt1", 32'(sbr_rsp[1].gnt), 32'd1);
        drain();

        // T3: two outstanding fill the FIFO; a pop does not unblock the same cycle
        step(1, 0, 32'h400, 32'h0, 1, 0, 32'h0);
        step(1, 0, 32'h404, 32'h0, 1, 0, 32'h0);
        step(1, 0, 32'h408, 32'h0, 1, 0, 32'h0);
        check("t3_full_req", 32'(mgr_req.req), 32'd0);
        step(1, 0, 32'h408, 32'h0, 1, 1, 32'h33);
        check("t3_pop_req", 32'(mgr_req.req), 32'd0);
        check("t3_pop_rv", 32'(sbr_rsp[0].rvalid), 32'd1);
        step(1, 0, 32'h408, 32'h0, 1, 0, 32'h0);
        check("t3_next_req", 32'(mgr_req.req), 32'd1);
        check("t3_next_gnt", 32'(sbr_rsp[0].gnt), 32'd1);
        drain();

        // T4: grants 1,0,1 with delayed responses A,B,C routed in order
        step(0, 1, 32'h0, 32'h500, 1, 0, 32'h0);
        check("t4_g1", 32'(sbr_rsp[1].gnt), 32'd1);
        step(1, 0, 32'h600, 32'h0, 1, 0, 32'h0);
        check("t4_g0", 32'(sbr_rsp[0].gnt), 32'd1);
        for (int k = 0; k < 3; k++) step(0, 1, 32'h0, 32'h504, 1, 0, 32'h0);
        step(0, 1, 32'h0, 32'h504, 1, 1, 32'hA);
        check("t4_rvA", 32'(sbr_rsp[1].rvalid), 32'd1);
        check("t4_rvA0", 32'(sbr_rsp[0].rvalid), 32'd0);
        check("t4_dA", sbr_rsp[1].r.rdata, 32'hA);
        step(0, 1, 32'h0, 32'h504, 1, 1, 32'hB);
        check("t4_g1b", 32'(sbr_rsp[1].gnt), 32'd1);
        check("t4_rvB", 32'(sbr_rsp[0].rvalid), 32'd1);
        check("t4_dB", sbr_rsp[0].r.rdata, 32'hB);
        for (int k = 0; k < 4; k++) step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 32'h0, 0, 1, 32'hC);
        check("t4_rvC", 32'(sbr_rsp[1].rvalid), 32'd1);
        check("t4_dC", sbr_rsp[1].r.rdata, 32'hC);

        // T5: stray rvalid with empty FIFO is dropped and flags a sticky error
        step(0, 0, 32'h0, 32'h0, 0, 1, 32'hDEAD);
        check("t5_rv0", 32'(sbr_rsp[0].rvalid), 32'd0);
        check("t5_rv1", 32'(sbr_rsp[1].rvalid), 32'd0);
        check("t5_err_same", 32'(proto_err), 32'd0);
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        check("t5_err_next", 32'(proto_err), 32'd1);
        for (int k = 0; k < 3; k++) step(1, 0, 32'h700 + k, 32'h0, 1, m_q.size() > 0, 32'h0);
        check("t5_err_sticky", 32'(proto_err), 32'd1);
        reset_cycle();
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        check("t5_err_clr", 32'(proto_err), 32'd0);

        // T6: five grants to mgr0; counter saturates when enabled, clears on reset
        for (int k = 0; k < 5; k++) step(1, 0, 32'h800 + k, 32'h0, 1, m_q.size() > 0, 32'h0);
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
`ifdef OBI_ARB_GNT_CNT_EN
        check("t6_sat", 32'(gnt_cnt[0]), 32'd3);
`else
        check("t6_tied", 32'(gnt_cnt[0]), 32'd0);
`endif
        reset_cycle();
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        check("t6_clr", 32'(gnt_cnt[0]), 32'd0);
        drain();

        // Random traffic obeying OBI request stability
        for (int c = 0; c < 600; c++) begin
            t_rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    t_req[i]  = ($urandom_range(0, 9) < 6);
                    t_addr[i] = $urandom;
                end
            end
            t_gnt   = ($urandom_range(0, 3) != 0);
            t_rv    = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            t_rdata = $urandom;
            cycle();
            for (int i = 0; i < N; i++) pend[i] = !t_rst && t_req[i] && (last_gnt_idx != i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
